// File: rtl/rv_stream_pkg.sv
// Shared helpers for the stream interconnect blocks: index widths and the
// round-robin pointer advance.
package rv_stream_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned p;
      int unsigned r;
      p = 1;
      r = 0;
      while (p < v) begin
         p = p << 1;
         r = r + 1;
      end
      return r;
   endfunction

   // A single channel still needs a 1-bit index port.
   function automatic int unsigned sel_w(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// found by a lowest-set-bit search over a doubled, ptr-masked request vector.
module rr_arbiter
   import rv_stream_pkg::*;
#(
   parameter  int unsigned N_CH  = 4,
   localparam int unsigned SEL_W = sel_w(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_CH-1:0]  grant,
   output logic [SEL_W-1:0] grant_idx,
   output logic             any_grant
);

   logic [2*N_CH-1:0] req_dbl;
   logic [2*N_CH-1:0] masked;
   int unsigned       pos;
   int unsigned       idx;

   always_comb begin
      req_dbl   = {req, req};
      masked    = '0;
      pos       = 0;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      // Lower copy keeps only bits >= ptr; upper copy supplies the wrap-around.
      for (int unsigned i = 0; i < 2 * N_CH; i++) begin
         masked[i] = req_dbl[i] & (i >= 32'(ptr));
      end
      // Descending scan so the lowest set bit is the last one written.
      for (int unsigned i = 2 * N_CH; i > 0; i--) begin
         if (masked[i-1]) begin
            pos       = i - 1;
            any_grant = 1'b1;
         end
      end
      idx = (pos >= N_CH) ? pos - N_CH : pos;
      if (any_grant) begin
         grant[idx] = 1'b1;
         grant_idx  = SEL_W'(idx);
      end
   end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream mux: round-robin select into a single
// full-throughput output register.
module rr_stream_mux
   import rv_stream_pkg::*;
#(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned N_CH  = 4,
   localparam int unsigned SEL_W = sel_w(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH*WIDTH-1:0]  in_data,
   input  logic [N_CH-1:0]        in_valid,
   output logic [N_CH-1:0]        in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [SEL_W-1:0]       out_ch,
   output logic                   out_valid,
   input  logic                   out_ready
);

   logic             load_en;
   logic [SEL_W-1:0] ptr;
   logic [N_CH-1:0]  grant;
   logic [SEL_W-1:0] grant_idx;
   logic             any_grant;
   logic [WIDTH-1:0] sel_data;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   assign load_en = ~out_valid | out_ready;

   always_comb begin
      in_ready = '0;
      if (rst_n && load_en) begin
         in_ready = grant;
      end
   end

   // One-hot AND-OR select; grant is never multi-hot.
   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (any_grant) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_idx;
            ptr       <= SEL_W'(rr_next(32'(grant_idx), N_CH));
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a 4-channel and a 3-channel instance.
module tb_rr_stream_mux;

   logic        clk;
   logic        rst_n;

   logic [127:0] in_data4;
   logic [3:0]   in_valid4;
   logic [3:0]   in_ready4;
   logic [31:0]  out_data4;
   logic [1:0]   out_ch4;
   logic         out_valid4;
   logic         out_ready4;

   logic [95:0]  in_data3;
   logic [2:0]   in_valid3;
   logic [2:0]   in_ready3;
   logic [31:0]  out_data3;
   logic [1:0]   out_ch3;
   logic         out_valid3;
   logic         out_ready3;

   int vectors;
   int miscompares;
   int q_ch4[$];
   int q_ch3[$];

   rr_stream_mux #(.WIDTH(32), .N_CH(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data4),
      .in_valid  (in_valid4),
      .in_ready  (in_ready4),
      .out_data  (out_data4),
      .out_ch    (out_ch4),
      .out_valid (out_valid4),
      .out_ready (out_ready4)
   );

   rr_stream_mux #(.WIDTH(32), .N_CH(3)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data3),
      .in_valid  (in_valid3),
      .in_ready  (in_ready3),
      .out_data  (out_data3),
      .out_ch    (out_ch3),
      .out_valid (out_valid3),
      .out_ready (out_ready3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One cycle on the 4-channel DUT; exp_ch < 0 means no acceptance expected.
   task automatic step4(input logic [3:0] v, input logic ordy, input int exp_ch, input string tag);
      logic [3:0]  exp_rdy;
      logic [31:0] exp_data;
      int          ch;
      in_valid4  = v;
      out_ready4 = ordy;
      exp_rdy    = (exp_ch >= 0) ? (4'b0001 << exp_ch) : 4'b0000;
      #1;
      vectors++;
      if (in_ready4 !== exp_rdy) begin
         miscompares++;
         $display("FAIL %s in_ready4: got %b want %b", tag, in_ready4, exp_rdy);
      end
      if (exp_ch >= 0) q_ch4.push_back(exp_ch);
      @(posedge clk);
      #1;
      if (exp_ch >= 0) begin
         ch       = q_ch4.pop_front();
         exp_data = 32'hA0 + 32'(ch);
         vectors++;
         if (out_valid4 !== 1'b1 || out_ch4 !== 2'(ch) || out_data4 !== exp_data) begin
            miscompares++;
            $display("FAIL %s out4: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     tag, out_valid4, out_ch4, out_data4, ch, exp_data);
         end
      end
   endtask

   task automatic step3(input logic [2:0] v, input int exp_ch, input string tag);
      logic [2:0]  exp_rdy;
      logic [31:0] exp_data;
      int          ch;
      in_valid3  = v;
      out_ready3 = 1'b1;
      exp_rdy    = (exp_ch >= 0) ? (3'b001 << exp_ch) : 3'b000;
      #1;
      vectors++;
      if (in_ready3 !== exp_rdy) begin
         miscompares++;
         $display("FAIL %s in_ready3: got %b want %b", tag, in_ready3, exp_rdy);
      end
      if (exp_ch >= 0) q_ch3.push_back(exp_ch);
      @(posedge clk);
      #1;
      if (exp_ch >= 0) begin
         ch       = q_ch3.pop_front();
         exp_data = 32'hB0 + 32'(ch);
         vectors++;
         if (out_valid3 !== 1'b1 || out_ch3 !== 2'(ch) || out_data3 !== exp_data) begin
            miscompares++;
            $display("FAIL %s out3: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                     tag, out_valid3, out_ch3, out_data3, ch, exp_data);
         end
      end
   endtask

   task automatic check_reset_state(input string tag);
      vectors++;
      if (out_valid4 !== 1'b0 || out_data4 !== 32'h0 || out_ch4 !== 2'd0 || in_ready4 !== 4'h0) begin
         miscompares++;
         $display("FAIL %s: got v=%b d=%h ch=%0d rdy=%b want v=0 d=0 ch=0 rdy=0",
                  tag, out_valid4, out_data4, out_ch4, in_ready4);
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      in_valid4  = 4'hF;
      out_ready4 = 1'b1;
      in_valid3  = 3'h0;
      out_ready3 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_reset_state($sformatf("reset_edge%0d", i));
      end
      rst_n = 1'b1;
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < 6; i++) step4(4'hF, 1'b1, i % 4, $sformatf("rr%0d", i));
   endtask

   task automatic test_sparse_wrap();
      step4(4'b1010, 1'b1, 3, "sparse0");
      step4(4'b1010, 1'b1, 1, "sparse1");
      step4(4'b1010, 1'b1, 3, "sparse2");
      step4(4'b1010, 1'b1, 1, "sparse3");
      step4(4'b0001, 1'b1, 0, "sparse_ch0");
   endtask

   task automatic test_backpressure();
      step4(4'b0100, 1'b1, 2, "bp_load");
      for (int i = 0; i < 3; i++) begin
         step4(4'hF, 1'b0, -1, $sformatf("bp_stall%0d", i));
         vectors++;
         if (out_valid4 !== 1'b1 || out_data4 !== 32'hA2 || out_ch4 !== 2'd2) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got v=%b d=%h ch=%0d want v=1 d=a2 ch=2",
                     i, out_valid4, out_data4, out_ch4);
         end
      end
      step4(4'hF, 1'b1, 3, "bp_release");
   endtask

   task automatic test_mid_reset();
      step4(4'hF, 1'b1, 0, "mr_pre0");
      step4(4'hF, 1'b1, 1, "mr_pre1");
      rst_n = 1'b0;
      #1;
      vectors++;
      if (in_ready4 !== 4'h0) begin
         miscompares++;
         $display("FAIL mr_ready_in_reset: got %b want 0000", in_ready4);
      end
      @(posedge clk);
      #1;
      check_reset_state("mr_after");
      rst_n = 1'b1;
      step4(4'hF, 1'b1, 0, "mr_first");
      step4(4'h0, 1'b1, -1, "idle");
      vectors++;
      if (out_valid4 !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_valid: got %b want 0", out_valid4);
      end
   endtask

   task automatic test_non_pow2();
      for (int i = 0; i < 7; i++) step3(3'h7, i % 3, $sformatf("np2_%0d", i));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      for (int i = 0; i < 4; i++) in_data4[i*32 +: 32] = 32'hA0 + 32'(i);
      for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = 32'hB0 + 32'(i);
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_sparse_wrap();
      test_backpressure();
      test_mid_reset();
      test_non_pow2();
      vectors++;
      if (q_ch4.size() != 0 || q_ch3.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", q_ch4.size(), q_ch3.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- A fair round-robin arbiter selects the channel each cycle; the selected word passes through one output register.
- Used in the RISC-V subsystem wherever several requesters share one downstream port, for example I-fetch, D-access and debug sharing one memory port.
- Supersedes fixed 2:1 select muxes at shared ports: the select is generated internally and flow control is added.

Parameters:
- WIDTH, 32, data bits per channel (>=1).
- N_CH, 4, number of input channels (>=1; non-power-of-2 allowed).
- SEL_W, derived localparam = max(1, clog2(N_CH)), width of the channel index; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_CH  channel i presents a word.
- in_ready  out  N_CH  channel i word accepted this cycle when in_valid[i] & in_ready[i].
- out_data  out  WIDTH  registered output word.
- out_ch  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  out_data/out_ch are valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready.

Behaviour:
- Reset: the block samples rst_n=0 at a clk edge. On that edge out_valid=0, out_data=0, out_ch=0, and the priority pointer ptr=0, so channel 0 has highest priority. in_ready is all-zero while rst_n=0.
- load_en = ~out_valid | out_ready. This gives one output stage with full throughput of one word per cycle.
- Arbitration is combinational each cycle. grant is one-hot and selects the first i with in_valid[i]=1, scanning ptr, ptr+1, … N_CH-1, 0, … ptr-1.
- If no in_valid bit is set, grant=0.
- in_ready[i] = load_en & grant[i]. At most one bit is set. in_ready may depend on in_valid; in_valid must not depend on in_ready.
- On a clk edge with load_en=1 and any grant:
  - out_data <= selected word; out_ch <= granted index; out_valid <= 1.
  - ptr <= granted index + 1, wrapping N_CH-1 -> 0. Wrap is explicit, so it is correct for non-power-of-2 N_CH.
- On a clk edge with load_en=1 and no grant: out_valid <= 0. out_data and out_ch hold their old values (don't-care). ptr holds.
- On a clk edge with load_en=0 (stall): out_data, out_ch, out_valid and ptr all hold. out_data must stay stable while out_valid & ~out_ready.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k. Back-to-back transfers sustain 1 word/cycle when out_ready=1.
- Fairness: a channel holding in_valid waits at most N_CH-1 grants.
- Simultaneous drain and load in the same cycle: a new word replaces the old word on that edge with no bubble.
- N_CH=1: grant = in_valid[0], out_ch is constant 0, ptr stays 0.
- Reset mid-operation: a pending output word is discarded (out_valid=0) and ptr returns to 0. Upstream must treat words not yet accepted as not transferred.
- No combinational path from out_ready to out_data/out_valid/out_ch. in_ready depends combinationally on out_ready and in_valid.

Decomposition:
- Shared package, rv_stream_pkg:
  - clog2 function.
  - SEL_W computation helper.
  - a round-robin next-pointer function (idx+1 with wrap at N_CH).
- Sub-module rr_arbiter (N_CH):
  - inputs: req, ptr.
  - outputs: one-hot grant, grant_idx, any_grant.
  - purely combinational, double-width mask scheme.
- rr_stream_mux contains:
  - the ptr register.
  - the output register with load_en.
  - the data select, an AND-OR over the one-hot grant, not a priority chain.

Test Plan:
- Reset: rst_n=0 for 2 edges while in_valid=4'hF. Check out_valid=0, out_data=0, out_ch=0, in_ready=0. Release reset; the first grant goes to ch0.
- Round-robin: N_CH=4, all in_valid=1 with data i=32'hA0+i, out_ready=1. Expected out_ch sequence is 0,1,2,3,0,1, one per cycle, with out_data 0xA0,0xA1,0xA2,0xA3.
- Sparse and wrap: only ch1 and ch3 valid, starting ptr=2. Grants go 3,1,3,1. Then ch0 alone becomes valid and is granted next cycle.
- Backpressure: out_valid=1 with out_data=0xA2. Hold out_ready=0 for 3 cycles. Check out_data/out_ch stable, in_ready=0, ptr unchanged. Raise out_ready; the next word loads on the same edge.
- Non-power-of-2: N_CH=3, all valid. Grants cycle 0,1,2,0; ptr never reaches 3; SEL_W=2.
- Mid-operation reset: out_valid=1 with ptr=2. Assert rst_n=0 for 1 edge. Check out_valid=0, then the next grant goes to ch0 with all channels valid.
